// File: rtl/multi_port_byte_mem.sv
// Byte-addressed memory with NUM_PORTS independent request ports and a fixed-latency,
// asynchronously reset response pipeline per port.
module multi_port_byte_mem #(
    parameter int unsigned MEM_BYTES  = 65536,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned WRITE_ACK  = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              p_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   p_addr,
    input  logic [NUM_PORTS*32-1:0]           p_wdata,
    input  logic [NUM_PORTS*4-1:0]            p_wstrb,
    output logic [NUM_PORTS*32-1:0]           p_rdata,
    output logic [NUM_PORTS-1:0]              p_rvalid,
    output logic [NUM_PORTS-1:0]              p_err
);

    localparam int unsigned IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic [7:0] mem [0:MEM_BYTES-1];

    logic [ADDR_WIDTH-1:0] base     [NUM_PORTS];
    logic [31:0]           rd_word  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  in_range;
    logic [NUM_PORTS-1:0]  is_wr;
    logic [NUM_PORTS-1:0]  resp;

    logic [RD_LATENCY-1:0] pv [NUM_PORTS];
    logic [RD_LATENCY-1:0] pe [NUM_PORTS];
    logic [31:0]           pd [NUM_PORTS][RD_LATENCY];

    function automatic logic [IDX_W-1:0] byte_idx(input logic [ADDR_WIDTH-1:0] b,
                                                  input int unsigned k);
        return b[IDX_W-1:0] + IDX_W'(k);
    endfunction

    function automatic int unsigned rev(input int unsigned n);
        return NUM_PORTS - 1 - n;
    endfunction

    // Request decode and read-first word fetch (mem still holds pre-write contents here)
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            base[i]     = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & ~ADDR_WIDTH'(3);
            in_range[i] = (32'(base[i]) + 32'd3) < MEM_BYTES;
            is_wr[i]    = |p_wstrb[i*4 +: 4];
            resp[i]     = p_valid[i] && (!is_wr[i] || (WRITE_ACK != 0));
            rd_word[i]  = '0;
            if (in_range[i]) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    rd_word[i][8*k +: 8] = mem[byte_idx(base[i], k)];
                end
            end
        end
    end

    // Ports are visited highest index first so the lowest-index writer is the last
    // non-blocking update to a shared byte and therefore wins.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned n = 0; n < NUM_PORTS; n++) begin
                if (p_valid[rev(n)] && in_range[rev(n)]) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (p_wstrb[rev(n)*4 + k]) begin
                            mem[byte_idx(base[rev(n)], k)] <= p_wdata[rev(n)*32 + 8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                pv[i] <= '0;
                pe[i] <= '0;
                for (int unsigned s = 0; s < RD_LATENCY; s++) begin
                    pd[i][s] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                pv[i][0] <= resp[i];
                pe[i][0] <= resp[i] && !in_range[i];
                pd[i][0] <= (resp[i] && in_range[i]) ? rd_word[i] : '0;
                for (int unsigned s = 1; s < RD_LATENCY; s++) begin
                    pv[i][s] <= pv[i][s-1];
                    pe[i][s] <= pe[i][s-1];
                    pd[i][s] <= pd[i][s-1];
                end
            end
        end
    end

    // Idle stages carry zero data and error, so outputs read as 0 without extra gating
    always_comb begin
        p_rvalid = '0;
        p_err    = '0;
        p_rdata  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            p_rvalid[i]          = pv[i][RD_LATENCY-1];
            p_err[i]             = pe[i][RD_LATENCY-1];
            p_rdata[i*32 +: 32]  = pd[i][RD_LATENCY-1];
        end
    end

endmodule
